// File: rtl/hamming_decoder_pipe.sv
// ---------------------------------------------------------------------------
// hamming_decoder_pipe
//
// Streaming Hamming(7,4) single-error-correcting decoder. This is the
// receive-side partner of hamming_encoder. Codewords come in over a
// valid/ready interface. Stage 1 captures the codeword together with its
// syndrome. Stage 2 captures the corrected data and the error status.
// Two saturating counters track output transfers and corrected words, for
// link-quality monitoring.
//
// Codeword map (position p is bit p-1):
//   cw[0]=p1 cw[1]=p2 cw[2]=d0 cw[3]=p4 cw[4]=d1 cw[5]=d2 cw[6]=d3
//
// Parameters
//   CNT_W         width of word_cnt / corr_cnt; both saturate at all-ones
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   in_valid      in_code is valid
//   in_ready      decoder accepts in_code this cycle
//                 (combinational from out_ready only)
//   in_code       7-bit codeword
//   out_valid     out_* fields are valid
//   out_ready     downstream accepts out_* this cycle
//   out_data      corrected data d[3:0]
//   out_err       non-zero syndrome seen, one bit was corrected
//   out_syndrome  {s4,s2,s1}, the position of the flipped bit when non-zero
//   clr_cnt       synchronous clear of both counters
//   word_cnt      output transfers since reset/clear
//   corr_cnt      output transfers with out_err set
// ---------------------------------------------------------------------------
module hamming_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_syndrome,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] in_syndrome;
    logic       s1_valid;
    logic [6:0] s1_code;
    logic [2:0] s1_syndrome;
    logic [6:0] flip_mask;
    logic [6:0] fixed_code;
    logic       s2_adv;
    logic       s1_adv;
    logic       out_xfer;

    // Each syndrome bit re-checks one parity group of the incoming word.
    // Read as a 3-bit number, the syndrome is the 1-based position of a
    // single flipped bit. A value of zero means the word is clean.
    always_comb begin
        in_syndrome[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
        in_syndrome[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
        in_syndrome[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
    end

    // Pipeline control. The output stage moves when it is empty or being
    // drained. Stage 1 moves when it is empty or the output stage moves.
    // This lets bubbles collapse. in_ready never looks at in_valid, so there
    // is no combinational loop through an upstream block.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
        out_xfer = out_valid && out_ready;
    end

    // Correction works on the stage-1 copy. The single bit named by the
    // syndrome is inverted, and the data bits are taken from the repaired
    // word. A parity-position error therefore leaves the data unchanged.
    always_comb begin
        flip_mask = '0;
        if (s1_syndrome != 3'd0) begin
            flip_mask[s1_syndrome - 3'd1] = 1'b1;
        end
        fixed_code = s1_code ^ flip_mask;
    end

    // Stage 1 register: codeword plus syndrome, loaded on each input
    // transfer. When stage 1 advances with no new input it simply becomes
    // empty. The payload is left alone because nothing reads it then.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_code     <= '0;
            s1_syndrome <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code     <= in_code;
                s1_syndrome <= in_syndrome;
            end
        end
    end

    // Stage 2 register: the visible output word. While a word is stalled
    // (valid and not accepted) nothing here changes. The fields only reload
    // when a real word arrives from stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_err      <= 1'b0;
            out_syndrome <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
                out_err      <= (s1_syndrome != 3'd0);
                out_syndrome <= s1_syndrome;
            end
        end
    end

    // Link-quality counters. They count completed output transfers and stop
    // at all-ones rather than wrapping. A clear wins over a transfer in the
    // same cycle, so that transfer is never counted.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (out_xfer) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (out_err && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder_pipe
//
// Self-checking bench for hamming_decoder_pipe.
//
// Two instances receive identical stimulus. The first uses the default
// 16-bit counters. The second uses 2-bit counters so that saturation is
// easy to reach.
//
// The reference model treats Hamming decoding as "XOR of the positions of
// all set bits". A scoreboard queue holds the words accepted and not yet
// delivered.
// ---------------------------------------------------------------------------
module tb_hamming_decoder_pipe;

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } exp_t;

    typedef struct {
        logic [6:0] code;
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_code;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_err;
    logic [2:0]  out_syndrome;
    logic        clr_cnt;
    logic [15:0] word_cnt;
    logic [15:0] corr_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [3:0]  out_data2;
    logic        out_err2;
    logic [2:0]  out_syndrome2;
    logic [1:0]  word_cnt2;
    logic [1:0]  corr_cnt2;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    int   wc, cc, wc2, cc2;
    logic last_in_x;
    logic pre_in_ready;

    hamming_decoder_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_syndrome(out_syndrome),
        .clr_cnt(clr_cnt), .word_cnt(word_cnt), .corr_cnt(corr_cnt)
    );

    hamming_decoder_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_err(out_err2), .out_syndrome(out_syndrome2),
        .clr_cnt(clr_cnt), .word_cnt(word_cnt2), .corr_cnt(corr_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Builds a codeword. The data bits go to positions 3,5,6,7. The parity
    // bits at 1,2,4 are then chosen so that the XOR of all set positions
    // is zero.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        int s;
        c    = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        s    = 0;
        for (int p = 1; p <= 7; p++) begin
            if (c[p-1]) s = s ^ p;
        end
        c[0] = s[0];
        c[1] = s[1];
        c[3] = s[2];
        return c;
    endfunction

    // Decodes a codeword. The syndrome is the XOR of the positions of all
    // set bits. A non-zero syndrome flips the bit at that position before
    // the data bits are extracted.
    function automatic exp_t refDecode(input logic [6:0] c);
        exp_t r;
        int s;
        logic [6:0] f;
        s = 0;
        for (int p = 1; p <= 7; p++) begin
            if (c[p-1]) s = s ^ p;
        end
        f = c;
        if (s != 0) f[s-1] = ~f[s-1];
        r.data = {f[6], f[5], f[4], f[2]};
        r.err  = (s != 0);
        r.syn  = 3'(s);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and checks the handshake and the delivered
    // words before the edge. It then advances the model and checks the
    // counters after the edge.
    task automatic applyStimulus(input logic v, input logic [6:0] c, input logic ordy,
                                 input logic clr, input logic r);
        logic in_x;
        logic out_x;
        logic head_err;
        exp_t head;
        in_valid  = v;
        in_code   = c;
        out_ready = ordy;
        clr_cnt   = clr;
        rst       = r;
        #1;
        pre_in_ready = in_ready;
        in_x     = v && in_ready;
        out_x    = out_valid && ordy;
        head_err = 1'b0;
        if (!r) begin
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || ordy});
            checkOutput("in_ready_w2", {31'd0, in_ready2}, {31'd0, (q.size() < 2) || ordy});
            if (out_x) begin
                if (q.size() == 0) begin
                    checkOutput("spurious_word", {31'd0, out_valid}, 32'd0);
                end else begin
                    head     = q.pop_front();
                    head_err = head.err;
                    checkOutput("sb_data", {28'd0, out_data}, {28'd0, head.data});
                    checkOutput("sb_err", {31'd0, out_err}, {31'd0, head.err});
                    checkOutput("sb_syn", {29'd0, out_syndrome}, {29'd0, head.syn});
                    checkOutput("sb_valid_w2", {31'd0, out_valid2}, 32'd1);
                    checkOutput("sb_data_w2", {28'd0, out_data2}, {28'd0, head.data});
                    checkOutput("sb_err_w2", {31'd0, out_err2}, {31'd0, head.err});
                    checkOutput("sb_syn_w2", {29'd0, out_syndrome2}, {29'd0, head.syn});
                end
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            wc = 0; cc = 0; wc2 = 0; cc2 = 0;
        end else begin
            if (in_x) q.push_back(refDecode(c));
            if (clr) begin
                wc = 0; cc = 0; wc2 = 0; cc2 = 0;
            end else if (out_x) begin
                if (wc < 65535) wc++;
                if (wc2 < 3) wc2++;
                if (head_err) begin
                    if (cc < 65535) cc++;
                    if (cc2 < 3) cc2++;
                end
            end
        end
        last_in_x = in_x && !r;
        checkOutput("word_cnt", {16'd0, word_cnt}, 32'(wc));
        checkOutput("corr_cnt", {16'd0, corr_cnt}, 32'(cc));
        checkOutput("word_cnt_w2", {30'd0, word_cnt2}, 32'(wc2));
        checkOutput("corr_cnt_w2", {30'd0, corr_cnt2}, 32'(cc2));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("drain_empty", 32'(q.size()), 32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        logic [6:0] base;
        logic [6:0] code;
        logic [3:0] snap;
        int k;
        int wc0;

        wc = 0; cc = 0; wc2 = 0; cc2 = 0;
        in_valid = 1'b0; in_code = '0; out_ready = 1'b0; clr_cnt = 1'b0; rst = 1'b1;

        // Reset state
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_data", {28'd0, out_data}, 32'd0);
        checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
        checkOutput("rst_out_syn", {29'd0, out_syndrome}, 32'd0);

        // Table of single words with known results
        base    = 7'b1010101;
        tbl[0]  = '{7'b0110011, 4'b0110, 1'b0, 3'd0};
        tbl[1]  = '{7'b0100011, 4'b0110, 1'b1, 3'd5};
        for (int p = 1; p <= 7; p++) begin
            tbl[1+p] = '{base ^ 7'(1 << (p-1)), 4'b1011, 1'b1, 3'(p)};
        end
        tbl[9]  = '{7'b0000000, 4'b0000, 1'b0, 3'd0};
        tbl[10] = '{7'b1111111, 4'b1111, 1'b0, 3'd0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, tbl[i].code, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("tbl%0d_lat_early", i), {31'd0, out_valid}, 32'd0);
            applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("tbl%0d_data", i), {28'd0, out_data}, {28'd0, tbl[i].data});
            checkOutput($sformatf("tbl%0d_err", i), {31'd0, out_err}, {31'd0, tbl[i].err});
            checkOutput($sformatf("tbl%0d_syn", i), {29'd0, out_syndrome}, {29'd0, tbl[i].syn});
            applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        end

        // Back-to-back burst with a 3-cycle downstream stall
        wc0 = wc;
        k   = 0;
        for (int i = 0; i < 14; i++) begin
            code = encode(4'(k));
            applyStimulus(k < 8, code, !(i >= 3 && i < 6), 1'b0, 1'b0);
            if (i == 2) snap = out_data;
            if (i >= 3 && i < 6) begin
                checkOutput("stall_in_ready", {31'd0, pre_in_ready}, 32'd0);
                checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stall_out_data", {28'd0, out_data}, 32'd1);
                checkOutput("stall_stable", {28'd0, out_data}, {28'd0, snap});
            end
            if (last_in_x) k++;
        end
        drain();
        checkOutput("stream_accepted", 32'(k), 32'd8);
        checkOutput("stream_count", {16'd0, word_cnt}, 32'(wc0 + 8));

        // Saturation of the 2-bit counters, then a clear that coincides with a transfer
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, encode(4'(j)) ^ 7'b0000100, 1'b1, 1'b0, 1'b0);
        end
        drain();
        checkOutput("sat_corr2", {30'd0, corr_cnt2}, 32'd3);
        checkOutput("sat_word2", {30'd0, word_cnt2}, 32'd3);
        checkOutput("sat_corr16", {16'd0, corr_cnt}, 32'd5);
        applyStimulus(1'b1, encode(4'd9) ^ 7'b1000000, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_pending_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_word_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("clr_corr_cnt", {16'd0, corr_cnt}, 32'd0);
        checkOutput("clr_corr_cnt2", {30'd0, corr_cnt2}, 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] d;
            int kind;
            d    = 4'($urandom);
            kind = int'($urandom_range(0, 3));
            code = encode(d);
            if (kind == 1 || kind == 2) code = code ^ 7'(1 << $urandom_range(0, 6));
            if (kind == 3) code = 7'($urandom);
            applyStimulus(($urandom % 4) != 0, code, ($urandom % 4) != 0,
                          ($urandom % 64) == 0, 1'b0);
        end
        drain();

        // Reset with both stages full discards everything in flight
        applyStimulus(1'b1, encode(4'd3), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, encode(4'd4), 1'b0, 1'b0, 1'b0);
        checkOutput("full_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, encode(4'd5), 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_word_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("midrst_corr_cnt", {16'd0, corr_cnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
            checkOutput("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
